// File: rtl/sijtag_pkg.sv
// Shared constants for the secure IJTAG segment: decode modes, capture
// status-bit layout and the lockout state encoding.
package sijtag_pkg;

  localparam int MODE_ONEHOT = 0;
  localparam int MODE_THERM  = 1;

  // Status bits sit directly above the code field in the capture word
  localparam int ST_ERR_IDX  = 0;
  localparam int ST_LOCK_IDX = 1;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/code_decode.sv
// Combinational select-code decoder: one-hot or thermometer enable vector,
// with an error flag for codes outside the output range.
module code_decode
  import sijtag_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 4,
  parameter int MODE  = MODE_ONEHOT
) (
  input  logic [IN_W-1:0]  code,
  output logic [OUT_W-1:0] vec,
  output logic             err
);

  always_comb begin
    err = (int'(code) >= OUT_W);
    vec = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (MODE == MODE_THERM) vec[i] = !err && (i <= int'(code));
      else                    vec[i] = (i == int'(code));
    end
  end

endmodule

// File: rtl/secure_scan_decoder.sv
// Key-gated IJTAG test data register whose update stage drives a registered
// decoded enable vector; repeated bad keys lock updates out until reset.
module secure_scan_decoder
  import sijtag_pkg::*;
#(
  parameter int              IN_W     = 3,
  parameter int              OUT_W    = 4,
  parameter int              KEY_W    = 8,
  parameter logic [KEY_W-1:0] KEY     = 8'hA5,
  parameter int              MAX_FAIL = 3,
  parameter int              MODE     = MODE_ONEHOT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             capture_en,
  input  logic             shift_en,
  input  logic             update_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic [OUT_W-1:0] dec_out,
  output logic             err,
  output logic             locked
);

  localparam int SR_W = KEY_W + IN_W;
  localparam int FW   = $clog2(MAX_FAIL + 1);

  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  cap_word;
  logic [IN_W-1:0]  code_q;
  logic             en_q;
  logic [OUT_W-1:0] dec_q;
  logic             err_q;
  logic [FW-1:0]    fail_q, fail_d;
  lock_state_t      state_q, state_d;

  logic             upd, key_ok, accept, lock_now;
  logic [OUT_W-1:0] dec_vec;
  logic             dec_err;

  code_decode #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .MODE  (MODE)
  ) u_decode (
    .code (sr[IN_W-1:0]),
    .vec  (dec_vec),
    .err  (dec_err)
  );

  // Update only fires when capture and shift are idle (capture > shift > update)
  assign upd    = sel && update_en && !capture_en && !shift_en;
  assign key_ok = (sr[SR_W-1:IN_W] == KEY);

  assign locked   = (state_q == LOCKED);
  assign scan_out = sr[0];
  assign err      = err_q;
  assign dec_out  = dec_q & {OUT_W{en_q}};

  // The key field always captures as zero so it can never be read back
  always_comb begin
    cap_word                    = '0;
    cap_word[IN_W-1:0]          = code_q;
    cap_word[IN_W+ST_ERR_IDX]   = err_q;
    cap_word[IN_W+ST_LOCK_IDX]  = locked;
  end

  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    accept   = 1'b0;
    lock_now = 1'b0;
    case (state_q)
      OPEN: begin
        if (upd) begin
          if (key_ok) begin
            accept = 1'b1;
            fail_d = '0;
          end else begin
            if (int'(fail_q) < MAX_FAIL) fail_d = fail_q + FW'(1);
            if (int'(fail_q) + 1 >= MAX_FAIL) begin
              state_d  = LOCKED;
              lock_now = 1'b1;
            end
          end
        end
      end
      LOCKED: state_d = LOCKED;
      default: state_d = OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OPEN;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      code_q <= '0;
      en_q   <= 1'b0;
      dec_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (sel && capture_en)    sr <= cap_word;
      else if (sel && shift_en) sr <= {scan_in, sr[SR_W-1:1]};
      if (accept) begin
        code_q <= sr[IN_W-1:0];
        en_q   <= 1'b1;
        dec_q  <= dec_vec;
        err_q  <= dec_err;
      end
      if (lock_now) begin
        en_q  <= 1'b0;
        dec_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_secure_scan_decoder.sv
// Bench for secure_scan_decoder: one-hot and thermometer instances share the
// same scan stimulus and are checked against a behavioural TDR model.
module tb_secure_scan_decoder;

  localparam int IN_W     = 3;
  localparam int OUT_W    = 4;
  localparam int KEY_W    = 8;
  localparam int SR_W     = KEY_W + IN_W;
  localparam int KEY      = 'hA5;
  localparam int MAX_FAIL = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sel = 1'b0, capture_en = 1'b0, shift_en = 1'b0, update_en = 1'b0, scan_in = 1'b0;
  logic             so0, err0, lk0, so1, err1, lk1;
  logic [OUT_W-1:0] dec0, dec1;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_sr, m_code, m_fail, m_dec0, m_dec1;
  bit m_err, m_locked;

  always #5 clk = ~clk;

  secure_scan_decoder #(.MODE(0)) dut0 (
    .clk(clk), .rst(rst), .sel(sel), .capture_en(capture_en), .shift_en(shift_en),
    .update_en(update_en), .scan_in(scan_in), .scan_out(so0), .dec_out(dec0),
    .err(err0), .locked(lk0)
  );

  secure_scan_decoder #(.MODE(1)) dut1 (
    .clk(clk), .rst(rst), .sel(sel), .capture_en(capture_en), .shift_en(shift_en),
    .update_en(update_en), .scan_in(scan_in), .scan_out(so1), .dec_out(dec1),
    .err(err1), .locked(lk1)
  );

  task automatic model_reset();
    m_sr = 0; m_code = 0; m_fail = 0; m_dec0 = 0; m_dec1 = 0;
    m_err = 0; m_locked = 0;
  endtask

  task automatic model_step(input bit c, input bit s, input bit u, input bit b, input bit sl);
    int key, code;
    if (!sl) return;
    if (c) begin
      m_sr = m_code | (int'(m_err) << IN_W) | (int'(m_locked) << (IN_W + 1));
    end else if (s) begin
      m_sr = (m_sr >> 1) | (int'(b) << (SR_W - 1));
    end else if (u && !m_locked) begin
      key  = m_sr >> IN_W;
      code = m_sr % (1 << IN_W);
      if (key == KEY) begin
        m_code = code;
        m_fail = 0;
        m_err  = (code >= OUT_W);
        m_dec0 = m_err ? 0 : (1 << code);
        m_dec1 = m_err ? 0 : ((1 << (code + 1)) - 1);
      end else begin
        if (m_fail < MAX_FAIL) m_fail++;
        if (m_fail == MAX_FAIL) begin
          m_locked = 1; m_dec0 = 0; m_dec1 = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit c, input bit s, input bit u, input bit b, input bit sl);
    sel = sl; capture_en = c; shift_en = s; update_en = u; scan_in = b;
    @(posedge clk);
    model_step(c, s, u, b, sl);
    #1;
    sel = 0; capture_en = 0; shift_en = 0; update_en = 0; scan_in = 0;
  endtask

  task automatic shift_word(input int key, input int code);
    logic [31:0] word;
    word = (key << IN_W) | code;
    for (int i = 0; i < SR_W; i++) cyc(0, 1, 0, word[i], 1);
  endtask

  task automatic update(input bit sl);
    cyc(0, 0, 1, 0, sl);
  endtask

  // Reset is raised between clock edges so its effect is purely asynchronous
  task automatic raise_rst();
    #2 rst = 1;
    #1;
  endtask

  task automatic drop_rst();
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    raise_rst();
    n_cmp++;
    if ({dec0, err0, lk0, so0} !== 7'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b required %b", {dec0, err0, lk0, so0}, 7'b0);
    end
    drop_rst();
    n_cmp++;
    if ({dec1, err1, lk1, so1} !== 7'b0) begin
      n_bad++; $display("FAIL reset_outputs_therm: got %b required %b", {dec1, err1, lk1, so1}, 7'b0);
    end
  endtask

  task automatic test_decode();
    shift_word(KEY, 2);
    update(1);
    n_cmp++;
    if ({dec0, err0, lk0} !== {4'b0100, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL onehot_code2: got %b required %b", {dec0, err0, lk0}, 6'b010000);
    end
    n_cmp++;
    if (dec1 !== 4'b0111) begin
      n_bad++; $display("FAIL therm_code2: got %b required %b", dec1, 4'b0111);
    end
    shift_word(KEY, 6);
    update(1);
    n_cmp++;
    if ({dec1, err1} !== {4'b0000, 1'b1}) begin
      n_bad++; $display("FAIL therm_illegal: got %b required %b", {dec1, err1}, 5'b00001);
    end
    n_cmp++;
    if ({dec0, err0} !== {4'b0000, 1'b1}) begin
      n_bad++; $display("FAIL onehot_illegal: got %b required %b", {dec0, err0}, 5'b00001);
    end
  endtask

  task automatic test_lockout();
    raise_rst(); drop_rst();
    shift_word(KEY, 2);
    update(1);
    for (int k = 1; k <= 3; k++) begin
      shift_word('h3C, 1);
      update(1);
      n_cmp++;
      if (k < 3 && {dec0, lk0} !== {4'b0100, 1'b0}) begin
        n_bad++; $display("FAIL bad_key_%0d: got %b required %b", k, {dec0, lk0}, 5'b01000);
      end else if (k == 3 && {dec0, dec1, lk0} !== {8'b0, 1'b1}) begin
        n_bad++; $display("FAIL lockout: got %b required %b", {dec0, dec1, lk0}, 9'b000000001);
      end
    end
    shift_word(KEY, 3);
    update(1);
    n_cmp++;
    if ({dec0, lk0} !== {4'b0000, 1'b1}) begin
      n_bad++; $display("FAIL locked_good_key: got %b required %b", {dec0, lk0}, 5'b00001);
    end
  endtask

  task automatic test_locked_readout();
    logic [SR_W-1:0] exp_word;
    exp_word = {6'b0, 1'b1, 1'b0, 3'b010};
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < SR_W; i++) begin
      n_cmp++;
      if (so0 !== exp_word[i]) begin
        n_bad++; $display("FAIL readout_bit%0d: got %b required %b", i, so0, exp_word[i]);
      end
      cyc(0, 1, 0, 1'($urandom_range(0, 1)), 1);
    end
  endtask

  task automatic test_fail_counter_clear();
    raise_rst(); drop_rst();
    shift_word('h11, 0); update(1);
    shift_word('h5A, 0); update(1);
    shift_word(KEY, 3);  update(1);
    n_cmp++;
    if ({dec0, lk0} !== {4'b1000, 1'b0}) begin
      n_bad++; $display("FAIL good_after_two_bad: got %b required %b", {dec0, lk0}, 5'b10000);
    end
    shift_word('h00, 1); update(1);
    shift_word('hA4, 1); update(1);
    n_cmp++;
    if ({dec0, lk0} !== {4'b1000, 1'b0}) begin
      n_bad++; $display("FAIL counter_cleared: got %b required %b", {dec0, lk0}, 5'b10000);
    end
  endtask

  task automatic test_async_reset();
    shift_word(KEY, 1); update(1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 1);
    raise_rst();
    n_cmp++;
    if ({dec0, err0, lk0, so0} !== 7'b0) begin
      n_bad++; $display("FAIL rst_mid_shift: got %b required %b", {dec0, err0, lk0, so0}, 7'b0);
    end
    drop_rst();
    for (int k = 0; k < 3; k++) begin shift_word('h3C, 1); update(1); end
    n_cmp++;
    if (lk0 !== 1'b1) begin
      n_bad++; $display("FAIL lock_before_rst: got %b required %b", lk0, 1'b1);
    end
    raise_rst();
    n_cmp++;
    if ({dec0, err0, lk0, so0} !== 7'b0) begin
      n_bad++; $display("FAIL rst_in_lockout: got %b required %b", {dec0, err0, lk0, so0}, 7'b0);
    end
    drop_rst();
    shift_word(KEY, 0); update(1);
    n_cmp++;
    if ({dec0, lk0} !== {4'b0001, 1'b0}) begin
      n_bad++; $display("FAIL fresh_update: got %b required %b", {dec0, lk0}, 5'b00010);
    end
    shift_word(KEY, 1); update(0);
    n_cmp++;
    if (dec0 !== 4'b0001) begin
      n_bad++; $display("FAIL unselected_update: got %b required %b", dec0, 4'b0001);
    end
  endtask

  task automatic test_random();
    bit c, s, u, b, sl;
    raise_rst(); drop_rst();
    for (int it = 0; it < 150; it++) begin
      if (it % 25 == 24) begin raise_rst(); drop_rst(); end
      shift_word(($urandom_range(0, 1) != 0) ? KEY : int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)));
      for (int j = 0; j < 3; j++) begin
        c  = ($urandom_range(0, 5) == 0);
        s  = ($urandom_range(0, 3) == 0);
        u  = ($urandom_range(0, 1) == 0);
        b  = 1'($urandom_range(0, 1));
        sl = ($urandom_range(0, 7) != 0);
        cyc(c, s, u, b, sl);
        n_cmp++;
        if ({dec0, dec1, err0, err1, lk0, so0, so1} !==
            {m_dec0[3:0], m_dec1[3:0], m_err, m_err, m_locked, m_sr[0], m_sr[0]}) begin
          n_bad++;
          $display("FAIL random_it%0d_%0d: got dec0=%b dec1=%b err=%b%b lk=%b so=%b%b required dec0=%b dec1=%b err=%b lk=%b so=%b",
                   it, j, dec0, dec1, err0, err1, lk0, so0, so1,
                   m_dec0[3:0], m_dec1[3:0], m_err, m_locked, m_sr[0]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_decode();
    test_lockout();
    test_locked_readout();
    test_fail_counter_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/secure_scan_decoder.md
Name: secure_scan_decoder

Overview:
- Parametrised successor to the combinational N-to-M `decoder`: an IJTAG-style test data register (TDR) whose update stage drives a registered decoded enable vector.
- Updates are key-gated. The shifted word must carry the correct key or the update is rejected.
- Repeated bad keys lock the block out until reset.
- Sits behind a SIB/segment select in the secure IJTAG network and drives instrument enables.

Parameters:
- IN_W, 3, width of select code field.
- OUT_W, 4, width of decoded output; codes >= OUT_W are illegal.
- KEY_W, 8, width of key field; must be >= 2.
- KEY, 8'hA5, unlock key compared on update.
- MAX_FAIL, 3, bad-key updates allowed before lockout (>= 1).
- MODE, 0, 0 = one-hot decode, 1 = thermometer decode (bits [code:0] set).

Ports:
- clk  in  1  TCK-domain clock, all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- sel  in  1  this TDR selected; capture/shift/update ignored when 0.
- capture_en  in  1  capture-DR.
- shift_en  in  1  shift-DR.
- update_en  in  1  update-DR.
- scan_in  in  1  serial data in.
- scan_out  out  1  serial data out = sr[0].
- dec_out  out  OUT_W  registered decoded enables.
- err  out  1  last accepted code illegal.
- locked  out  1  lockout active.

Behaviour:
- Shift register sr, width SR_W = KEY_W + IN_W. Field layout: sr[IN_W-1:0] = code, sr[SR_W-1:IN_W] = key. Shifting is LSB-out: on shift, sr <= {scan_in, sr[SR_W-1:1]}.
- Control priority when several enables are high with sel=1: capture > shift > update. With sel=0, nothing changes and scan_out still shows sr[0].
- Capture: sr[IN_W-1:0] <= code_q; sr[IN_W] <= err; sr[IN_W+1] <= locked; remaining bits <= 0. The key is never readable.
- Update when not locked and sr key field == KEY:
  - code_q <= code field; en_q <= 1; fail_cnt <= 0.
  - err <= (code >= OUT_W).
  - dec_out <= decode(code) on the same edge, so it is visible the cycle after update_en (latency 1).
- Update when not locked and key mismatch:
  - code_q, dec_out and err unchanged.
  - fail_cnt increments, saturating at MAX_FAIL.
  - When fail_cnt reaches MAX_FAIL, locked <= 1 on that same edge and dec_out <= 0.
- Locked state:
  - All updates are ignored and dec_out is held at 0.
  - Capture and shift still work, so status can be read out.
  - Only rst clears the lockout.
- Decode:
  - Illegal code (>= OUT_W): all zeros, err = 1.
  - Legal code, MODE=0: dec_out[code] = 1.
  - Legal code, MODE=1: dec_out[i] = 1 for i <= code.
- Reset (async, any time, including mid-shift):
  - sr = 0, code_q = 0, en_q = 0, fail_cnt = 0.
  - dec_out = 0, err = 0, locked = 0; scan_out = 0.
- fail_cnt width is $clog2(MAX_FAIL+1).

Decomposition:
- Shared package `sijtag_pkg`: decode-mode constants (MODE_ONEHOT=0, MODE_THERM=1) and a status-bit index localparam for the capture layout.
- One natural sub-module: `code_decode`, purely combinational. It takes code, MODE and OUT_W and returns {err, vec}; it is the successor to `decoder`.
- The TDR, key check and lockout FSM (states OPEN, LOCKED) stay in the top.

Test Plan:
1. Reset, then shift {8'hA5, 3'b010} (11 clocks), then update -> next cycle dec_out = 4'b0100, err = 0, locked = 0.
2. Same with MODE=1, code 3'b010 -> dec_out = 4'b0111; code 3'b110 -> dec_out = 4'b0000, err = 1.
3. From dec_out = 4'b0100, shift key 8'h3C with code 3'b001, then update -> dec_out stays 4'b0100. Repeat twice more -> on the 3rd update locked = 1 and dec_out = 0. A subsequent correct-key update leaves dec_out = 0.
4. In lockout, capture then shift 11 bits -> scan_out stream, LSB first, = code_q bits, err = 0, locked = 1, zeros.
5. Two bad keys, then a correct key with code 3'b011 -> dec_out = 4'b1000 and fail_cnt = 0. Two further bad keys -> no lockout.
6. Assert rst mid-shift (after 5 bits) and in lockout -> all outputs 0 asynchronously, locked = 0. A fresh good update with code 0 -> dec_out = 4'b0001. Also: update_en with sel = 0 -> no change.
